// File: rtl/serial_ones_counter.sv
// serial_ones_counter: bit-serial popcount of a WIDTH-bit word over valid/ready,
// with a saturating running total of delivered counts.
module serial_ones_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [TOT_W-1:0] total,
  input  logic             total_clr,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_sreg, w_sreg_nx;
  logic [CNT_W-1:0] r_acc, w_acc_nx, w_acc_add;
  logic [CNT_W-1:0] r_bitcnt, w_bitcnt_nx;
  logic [CNT_W-1:0] r_out_count, w_out_count_nx;
  logic [TOT_W-1:0] r_total, w_total_nx, w_base;
  logic [TOT_W:0]   w_sum;
  logic             r_in_ready, r_out_valid, r_busy;
  assign w_acc_add = r_acc + CNT_W'(r_sreg[0]);
  // clear wins over the old total, then the delivered count is added on top
  assign w_base = total_clr ? '0 : r_total;
  assign w_sum  = {1'b0, w_base} + (TOT_W+1)'(r_out_count);
  always_comb begin
    w_state_nx     = r_state;
    w_sreg_nx      = r_sreg;
    w_acc_nx       = r_acc;
    w_bitcnt_nx    = r_bitcnt;
    w_out_count_nx = r_out_count;
    w_total_nx     = w_base;
    case (r_state)
      IDLE: if (in_valid) begin
        w_sreg_nx   = in_data;
        w_acc_nx    = '0;
        w_bitcnt_nx = '0;
        w_state_nx  = SHIFT;
      end
      SHIFT: begin
        w_acc_nx    = w_acc_add;
        w_sreg_nx   = r_sreg >> 1;
        w_bitcnt_nx = r_bitcnt + 1'b1;
        if (r_bitcnt == CNT_W'(WIDTH-1)) begin
          w_state_nx     = HOLD;
          w_out_count_nx = w_acc_add;
        end
      end
      HOLD: if (out_ready) begin
        w_state_nx = IDLE;
        w_total_nx = w_sum[TOT_W] ? '1 : w_sum[TOT_W-1:0];
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_acc       <= '0;
      r_bitcnt    <= '0;
      r_out_count <= '0;
      r_total     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_sreg      <= w_sreg_nx;
      r_acc       <= w_acc_nx;
      r_bitcnt    <= w_bitcnt_nx;
      r_out_count <= w_out_count_nx;
      r_total     <= w_total_nx;
      r_in_ready  <= w_state_nx == IDLE;
      r_out_valid <= w_state_nx == HOLD;
      r_busy      <= w_state_nx != IDLE;
    end
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign total     = r_total;
  assign busy      = r_busy;
endmodule
